// File: rtl/seq_frame_tx.sv
// Serial frame transmitter: 1101 preamble, MSB-first payload with zero
// stuffing after every 1,1,0 run, then a forced-zero gap before the next byte.
module seq_frame_tx #(
    parameter int GAP_BITS = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       dout,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        DATA = 2'd2,
        GAP  = 2'd3
    } state_t;

    localparam logic [3:0] PRE_PAT  = 4'b1101;
    localparam logic [3:0] GAP_LAST = 4'(GAP_BITS - 1);

    state_t     state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [3:0] pidx_q,  pidx_d;
    logic [3:0] cnt_q,   cnt_d;
    logic [2:0] hist_q,  hist_d;
    logic       dout_q,  dout_d;
    logic       busy_q,  busy_d;
    logic       done_q,  done_d;

    // What the next payload slot would carry: a stuffed zero or the next data bit.
    logic       stuff;
    logic       pay_bit;
    logic [7:0] pay_shift;
    logic [3:0] pay_idx;
    logic       pay_last;

    always_comb begin
        stuff     = (hist_q == 3'b110) && (pidx_q < 4'd8);
        pay_bit   = stuff ? 1'b0 : shift_q[7];
        pay_shift = stuff ? shift_q : {shift_q[6:0], 1'b0};
        pay_idx   = stuff ? pidx_q : pidx_q + 4'd1;
        pay_last  = !stuff && (pidx_q == 4'd7);
    end

    // state_q always describes the bit currently on dout; _d values are the next bit.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        pidx_d  = pidx_q;
        cnt_d   = cnt_q;
        dout_d  = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (valid) begin
                    state_d = PRE;
                    shift_d = data;
                    pidx_d  = 4'd0;
                    cnt_d   = 4'd0;
                    dout_d  = PRE_PAT[3];
                    busy_d  = 1'b1;
                end
            end
            PRE: begin
                busy_d = 1'b1;
                if (cnt_q == 4'd3) begin
                    state_d = DATA;
                    dout_d  = pay_bit;
                    shift_d = pay_shift;
                    pidx_d  = pay_idx;
                    done_d  = pay_last;
                end else begin
                    cnt_d  = cnt_q + 4'd1;
                    dout_d = PRE_PAT[2'd2 - cnt_q[1:0]];
                end
            end
            DATA: begin
                busy_d = 1'b1;
                if (pidx_q == 4'd8) begin
                    state_d = GAP;
                    cnt_d   = 4'd0;
                end else begin
                    dout_d  = pay_bit;
                    shift_d = pay_shift;
                    pidx_d  = pay_idx;
                    done_d  = pay_last;
                end
            end
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d  = cnt_q + 4'd1;
                    busy_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                pidx_d  = 4'd0;
                cnt_d   = 4'd0;
            end
        endcase
        hist_d = {hist_q[1:0], dout_d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shift_q <= '0;
            pidx_q  <= '0;
            cnt_q   <= '0;
            hist_q  <= '0;
            dout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            pidx_q  <= pidx_d;
            cnt_q   <= cnt_d;
            hist_q  <= hist_d;
            dout_q  <= dout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Gated by rst_n so a byte held through reset is taken on the first live edge.
    assign ready = rst_n && (state_q == IDLE);
    assign dout  = dout_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_seq_frame_tx.sv
// Bench for seq_frame_tx: directed frames plus 1000 random bytes, compared
// cycle by cycle against a frame-list model and decoded back from dout.
module tb_seq_frame_tx;

    localparam int GAP = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] data = 8'h00;
    logic       valid = 1'b0;
    logic       ready, dout, busy, done;

    seq_frame_tx #(.GAP_BITS(GAP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .data  (data),
        .valid (valid),
        .ready (ready),
        .dout  (dout),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        else
            n_pass++;
    endtask

    // Model: every accepted byte becomes a list of future output cycles.
    typedef struct packed {
        logic d;
        logic bz;
        logic dn;
    } item_t;

    item_t      q[$];
    item_t      cur = '0;
    logic [7:0] exp_bytes[$];
    int         n_acc = 0;

    function automatic void push_frame(input logic [7:0] b);
        logic [3:0] pre;
        logic [2:0] h;
        pre = 4'b1101;
        h   = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            q.push_back('{pre[i], 1'b1, 1'b0});
            h = {h[1:0], pre[i]};
        end
        for (int i = 7; i >= 0; i--) begin
            if (h == 3'b110) begin
                q.push_back('{1'b0, 1'b1, 1'b0});
                h = {h[1:0], 1'b0};
            end
            q.push_back('{b[i], 1'b1, (i == 0)});
            h = {h[1:0], b[i]};
        end
        for (int i = 0; i < GAP; i++) q.push_back('{1'b0, 1'b1, 1'b0});
        q.push_back('{1'b0, 1'b0, 1'b0});
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            exp_bytes.delete();
            cur = '0;
        end else begin
            if (q.size() == 0 && valid) begin
                push_frame(data);
                exp_bytes.push_back(data);
                n_acc++;
            end
            if (q.size() != 0) cur = q.pop_front();
            else               cur = '0;
        end
    end

    // Monitor: per-cycle compare, optional log, and a preamble/unstuff decoder.
    logic       mon_en = 1'b0;
    logic       log_en = 1'b0;
    logic       log_q[$];
    logic [3:0] win = '0;
    logic [2:0] dh = '0;
    logic [7:0] acc = '0;
    logic [7:0] e_byte;
    logic       in_frame = 1'b0;
    int         nb = 0;
    int         n_pre = 0;
    int         n_dec = 0;

    always @(negedge clk) begin
        if (mon_en) begin
            check("dout",  32'(dout),  32'(cur.d));
            check("busy",  32'(busy),  32'(cur.bz));
            check("done",  32'(done),  32'(cur.dn));
            check("ready", 32'(ready), 32'(rst_n && (q.size() == 0)));
            if (log_en) log_q.push_back(dout);
            if (!rst_n) begin
                win = '0;
                in_frame = 1'b0;
                nb = 0;
            end else begin
                win = {win[2:0], dout};
                if (win == 4'b1101) n_pre++;
                if (in_frame) begin
                    if (dh == 3'b110) begin
                        check("stuff_zero", 32'(dout), 32'd0);
                    end else begin
                        acc = {acc[6:0], dout};
                        nb++;
                    end
                    dh = {dh[1:0], dout};
                    if (nb == 8) begin
                        in_frame = 1'b0;
                        if (exp_bytes.size() == 0) begin
                            check("dec_extra", 32'(acc), 32'hffff_ffff);
                        end else begin
                            e_byte = exp_bytes.pop_front();
                            check("dec_byte", 32'(acc), 32'(e_byte));
                            $display("frame %0d: sent %02h decoded %02h", n_dec, e_byte, acc);
                            n_dec++;
                        end
                    end
                end else if (win == 4'b1101) begin
                    in_frame = 1'b1;
                    dh = 3'b101;
                    nb = 0;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (q.size() != 0 && k < 100) begin
            step();
            k++;
        end
        check("idle_wait", 32'(k < 100), 32'd1);
    endtask

    // One handshake, then capture len+GAP bits of dout and compare to a literal.
    task automatic frame_check(input string tag, input logic [7:0] b, input int len,
                               input logic [15:0] exp);
        logic [15:0] got;
        int n, dcnt, dpos, bcnt;
        wait_idle();
        valid = 1'b1;
        data  = b;
        @(posedge clk);
        #2;
        valid = 1'b0;
        data  = ~b;
        n = len + GAP;
        got = '0;
        dcnt = 0;
        dpos = -1;
        bcnt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            got = {got[14:0], dout};
            if (done) begin
                dcnt++;
                dpos = i;
            end
            if (busy) bcnt++;
        end
        check({tag, "_bits"},     32'(got),  32'(exp));
        check({tag, "_done_cnt"}, 32'(dcnt), 32'd1);
        check({tag, "_done_pos"}, 32'(dpos), 32'(len - 1));
        check({tag, "_busy_cyc"}, 32'(bcnt), 32'(n));
        @(negedge clk);
        check({tag, "_ready_back"}, 32'(ready), 32'd1);
        check({tag, "_busy_low"},   32'(busy),  32'd0);
        $display("%s: byte %02h frame %b", tag, b, got);
    endtask

    initial begin
        int k, acc0, z, idx, pcnt;

        #3;
        rst_n  = 1'b0;
        mon_en = 1'b1;
        step();
        step();
        valid = 1'b1;
        data  = 8'h00;
        step();
        rst_n = 1'b1;
        #1;
        check("ready_after_rst", 32'(ready), 32'd1);

        frame_check("f00", 8'h00, 12, 16'b0011010000000000);
        frame_check("fB6", 8'hB6, 14, 16'b1101100110011000);
        frame_check("fD0", 8'hD0, 13, 16'b0110111001000000);

        // Two bytes with valid held high: 3 zeros between frames.
        wait_idle();
        log_q.delete();
        valid = 1'b1;
        data  = 8'hFF;
        @(posedge clk);
        log_en = 1'b1;
        #2;
        data = 8'h03;
        acc0 = n_acc;
        k = 0;
        while (n_acc == acc0 && k < 40) begin
            step();
            k++;
        end
        check("b2b_accept", 32'(n_acc - acc0), 32'd1);
        valid = 1'b0;
        repeat (16) @(negedge clk);
        log_en = 1'b0;
        pcnt = 0;
        for (int i = 3; i < log_q.size(); i++)
            if ({log_q[i-3], log_q[i-2], log_q[i-1], log_q[i]} == 4'b1101) pcnt++;
        check("b2b_preambles", 32'(pcnt), 32'd2);
        z = 0;
        idx = 12;
        while (idx < log_q.size() && log_q[idx] == 1'b0) begin
            z++;
            idx++;
        end
        check("b2b_gap_zeros", 32'(z), 32'd3);
        $display("b2b: FF then 03, zeros between frames %0d", z);

        // Reset in the middle of 0x5A's payload, then a fresh 0x81 frame.
        wait_idle();
        valid = 1'b1;
        data  = 8'h5A;
        @(posedge clk);
        #2;
        valid = 1'b0;
        data  = 8'h00;
        repeat (7) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_dout", 32'(dout),  32'd0);
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_busy", 32'(busy),  32'd0);
        $display("reset: asserted during payload of 5A");
        step();
        step();
        rst_n = 1'b1;
        frame_check("f81", 8'h81, 13, 16'b0110110000000100);

        // Random stream; producer keeps each byte steady until it is taken.
        for (int n = 0; n < 1000; n++) begin
            repeat ($urandom_range(0, 3)) begin
                valid = 1'b0;
                data  = 8'($urandom);
                step();
            end
            valid = 1'b1;
            data  = 8'($urandom);
            acc0 = n_acc;
            k = 0;
            while (n_acc == acc0 && k < 60) begin
                step();
                k++;
            end
            check("rnd_accept", 32'(n_acc - acc0), 32'd1);
        end
        valid = 1'b0;
        wait_idle();
        repeat (3) step();

        check("preamble_count", 32'(n_pre), 32'(n_acc));
        check("decoded_count",  32'(n_dec), 32'(n_acc - 1));
        check("pending_bytes",  32'(exp_bytes.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/seq_frame_tx.md
SEQ_FRAME_TX -- requirements
Module: seq_frame_tx

Interface
REQ-001 Parameter: GAP_BITS, default 2, number of forced-0 gap bits after each frame; legal range is 2..15.
REQ-002 clk  input  1  single clock; all state and dout update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 data  input  8  payload byte, transmitted MSB first.
REQ-005 valid  input  1  producer has a byte on data.
REQ-006 ready  output  1  block can accept a byte; a byte transfers on a rising edge with valid=1 and ready=1.
REQ-007 dout  output  1  serial line, one bit per clock, registered.
REQ-008 busy  output  1  high while a frame or gap is in progress.
REQ-009 done  output  1  one-cycle pulse in the cycle the last payload bit is on dout.

Function
REQ-010 The FSM SHALL use four states: IDLE, PRE, DATA and GAP.
REQ-011 IDLE: dout=0, ready=1, busy=0; on handshake, capture data into the shift register and go to PRE.
REQ-012 PRE: drive the sync preamble 1,1,0,1 on dout in the four cycles directly after the handshake edge, then go to DATA.
REQ-013 DATA: drive payload bits MSB first, one per cycle, applying the stuffing rule in REQ-014.
REQ-014 Stuffing: keep a 3-bit history of the last bits on dout; when it reads 1,1,0 (oldest to newest) and payload bits remain, drive a stuffed 0 instead of the next payload bit, and do not advance the payload index.
REQ-015 Stuffing SHALL NOT apply after the 8th payload bit or during PRE.
REQ-016 A frame SHALL contain at most 2 stuffed bits, giving a total length of 12..14 bits.
REQ-017 After the 8th payload bit, enter GAP and drive dout=0 for GAP_BITS cycles, then return to IDLE.
REQ-018 ready SHALL be 1 only in IDLE; valid outside IDLE is ignored and the byte stays pending at the producer.
REQ-019 Minimum spacing between frames is GAP_BITS+1 zero bits (GAP plus the IDLE accept cycle).
REQ-020 A back-to-back period of 15 cycles SHALL be achieved when GAP_BITS=2 and no bits are stuffed.
REQ-021 The data input may change after the handshake; the transmitted payload is the captured value.
REQ-022 The dout stream SHALL contain the pattern 1101 only at preamble positions, including across frame boundaries.
REQ-023 done SHALL be 1 for exactly one cycle per frame, coincident with payload bit 0 on dout.
REQ-024 busy SHALL be 1 in PRE, DATA and GAP.
REQ-025 Any undefined state encoding SHALL recover to IDLE on the next edge with dout=0.

Reset
REQ-026 rst_n low SHALL immediately force state=IDLE, dout=0, busy=0, done=0, ready=0, history=000 and payload index=0.
REQ-027 ready SHALL rise in the first cycle after rst_n deasserts.
REQ-028 A reset mid-frame SHALL abandon the frame with no partial resume; the next accepted byte starts a fresh preamble.
REQ-029 valid held high during reset SHALL be accepted only on the first rising edge with rst_n high.

Verification
REQ-030 data=0x00, one handshake -> dout = 1101 00000000 then 00, done pulses with the 12th bit, and ready returns 1 cycle after the gap.
REQ-031 data=0xB6 -> dout = 1101 1 0 [0] 1 1 0 [0] 1 1 0 then 00; 14 bits with 2 stuffs; busy is high for 16 cycles.
REQ-032 data=0xD0 -> dout = 1101 1 1 0 [0] 1 0 0 0 0; 13 bits with 1 stuff.
REQ-033 valid held high with bytes 0xFF then 0x03 -> frames separated by exactly 3 zeros; a pattern detector on dout reports 1101 only at the 2 preambles.
REQ-034 rst_n pulled low during payload bit 4 of 0x5A -> dout=0 and ready=0 within the same cycle; after release, 0x81 is sent as a complete 1101 10000001 frame.
REQ-035 Randomized stream of 1000 bytes -> the bench decodes (preamble, unstuff) to reproduce every byte in order, and 1101 never appears outside a preamble.
